// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with a one-entry skid buffer so that InReady can be
// a registered signal while downstream back-pressure is absorbed without loss.
module mem_wb_skid_stage #(
  parameter int DATA_W     = 32,
  parameter int RD_W       = 7,
  parameter int BR_W       = 7,
  parameter bit ZERO_GUARD = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] Result,
  input  logic [RD_W-1:0]   RdWb,
  input  logic [BR_W-1:0]   BranchResult,
  input  logic              Wrenable,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] ResultOut,
  output logic [RD_W-1:0]   RdWbOut,
  output logic [BR_W-1:0]   BranchResultOut,
  output logic              WrenableOut,
  output logic [1:0]        Occupancy,
  output logic [CNT_W-1:0]  StallCount
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [RD_W-1:0]   rd;
    logic [BR_W-1:0]   br;
    logic              we;
  } entry_t;

  state_e             state_q, state_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  entry_t             in_entry;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               accept, release_ev;

  assign InReady    = (state_q != FULL);
  assign OutValid   = (state_q != EMPTY);
  assign accept     = InValid && InReady;
  assign release_ev = OutValid && OutReady;

  // Writes to register 0 are dropped at capture so nothing downstream needs to care.
  always_comb begin
    in_entry        = '0;
    in_entry.result = Result;
    in_entry.rd     = RdWb;
    in_entry.br     = BranchResult;
    in_entry.we     = Wrenable && !(ZERO_GUARD && (RdWb == '0));
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = in_entry;
        end
      end
      ONE: begin
        if (accept && release_ev) begin
          main_d = in_entry;
        end else if (accept) begin
          state_d = FULL;
          skid_d  = in_entry;
        end else if (release_ev) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (release_ev) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (Flush) state_d = EMPTY;
  end

  // Back-pressure counter saturates and deliberately ignores Flush.
  always_comb begin
    stall_d = stall_q;
    if (OutValid && !OutReady && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign ResultOut       = main_q.result;
  assign RdWbOut         = main_q.rd;
  assign BranchResultOut = main_q.br;
  assign WrenableOut     = main_q.we && OutValid;
  assign Occupancy       = state_q;
  assign StallCount      = stall_q;

endmodule
